// File: rtl/dma_ch_sched_if.sv
// Channel-side and DMA-side signal bundle for dma_ch_sched.
// master = scheduler, slave = software channels plus DMA engine.
interface dma_ch_sched_if #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
);
   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0]        ch_valid_i;
   logic [NUM_CH-1:0]        ch_ready_o;
   logic [NUM_CH*ADDR_W-1:0] ch_src_i;
   logic [NUM_CH*ADDR_W-1:0] ch_dst_i;
   logic [NUM_CH*LEN_W-1:0]  ch_len_i;
   logic                     dma_valid_o;
   logic                     dma_ready_i;
   logic [ADDR_W-1:0]        dma_src_o;
   logic [ADDR_W-1:0]        dma_dst_o;
   logic [LEN_W-1:0]         dma_len_o;
   logic                     dma_done_i;
   logic                     dma_err_i;
   logic [NUM_CH-1:0]        irq_o;
   logic [NUM_CH-1:0]        err_o;
   logic [NUM_CH-1:0]        irq_clr_i;
   logic                     busy_o;
   logic [CH_W-1:0]          active_ch_o;

   modport master (
      input  ch_valid_i, ch_src_i, ch_dst_i, ch_len_i,
      input  dma_ready_i, dma_done_i, dma_err_i, irq_clr_i,
      output ch_ready_o, dma_valid_o, dma_src_o, dma_dst_o, dma_len_o,
      output irq_o, err_o, busy_o, active_ch_o
   );

   modport slave (
      output ch_valid_i, ch_src_i, ch_dst_i, ch_len_i,
      output dma_ready_i, dma_done_i, dma_err_i, irq_clr_i,
      input  ch_ready_o, dma_valid_o, dma_src_o, dma_dst_o, dma_len_o,
      input  irq_o, err_o, busy_o, active_ch_o
   );
endinterface

// File: rtl/dma_ch_sched.sv
// Round-robin descriptor scheduler: one slot per channel, one DMA transfer in flight.
// Optional WAIT watchdog enabled by defining DMA_SCHED_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | pick next full slot; zero-length descriptors complete here
// ISSUE  | descriptor presented to DMA, held until dma_ready_i
// WAIT   | transfer in flight, waiting for dma_done_i (or watchdog)
module dma_ch_sched #(
   parameter int NUM_CH      = 4,
   parameter int ADDR_W      = 32,
   parameter int LEN_W       = 16,
   parameter int TIMEOUT_CYC = 65535
) (
   input logic             clk_i,
   input logic             rst_i,
   dma_ch_sched_if.master  bus
);
   localparam int CH_W = $clog2(NUM_CH);

   if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
      $error("dma_ch_sched: NUM_CH must be 2..8");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("dma_ch_sched: TIMEOUT_CYC must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t             state_q, state_d;
   logic [NUM_CH-1:0]  full_q, irq_q, err_q;
   logic [NUM_CH-1:0]  irq_set, err_set, slot_free;
   logic [ADDR_W-1:0]  src_q [NUM_CH];
   logic [ADDR_W-1:0]  dst_q [NUM_CH];
   logic [LEN_W-1:0]   len_q [NUM_CH];
   logic [CH_W-1:0]    rr_q, rr_d, act_q, act_d, win, idx;
   logic               win_vld, load_dma;
   logic [ADDR_W-1:0]  dma_src_q, dma_dst_q;
   logic [LEN_W-1:0]   dma_len_q;

`ifdef DMA_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0]    to_cnt_q;

   // Loaded on entry to WAIT so that zero is reached in WAIT cycle TIMEOUT_CYC.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         to_cnt_q <= '0;
      end else if (state_q == S_ISSUE && bus.dma_ready_i) begin
         to_cnt_q <= TO_W'(TIMEOUT_CYC - 1);
      end else if (state_q == S_WAIT && to_cnt_q != '0) begin
         to_cnt_q <= to_cnt_q - TO_W'(1);
      end
   end
`endif

   // First full slot at or after the round-robin pointer.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = CH_W'((int'(rr_q) + i) % NUM_CH);
         if (!win_vld && full_q[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      act_d     = act_q;
      load_dma  = 1'b0;
      irq_set   = '0;
      err_set   = '0;
      slot_free = '0;
      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               rr_d = (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);
               if (len_q[win] == '0) begin
                  irq_set[win]   = 1'b1;
                  slot_free[win] = 1'b1;
               end else begin
                  act_d    = win;
                  load_dma = 1'b1;
                  state_d  = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (bus.dma_ready_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.dma_done_i) begin
               irq_set[act_q]   = 1'b1;
               err_set[act_q]   = bus.dma_err_i;
               slot_free[act_q] = 1'b1;
               state_d          = S_IDLE;
`ifdef DMA_SCHED_TIMEOUT_EN
            end else if (to_cnt_q == '0) begin
               irq_set[act_q]   = 1'b1;
               err_set[act_q]   = 1'b1;
               slot_free[act_q] = 1'b1;
               state_d          = S_IDLE;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         rr_q      <= '0;
         act_q     <= '0;
         full_q    <= '0;
         irq_q     <= '0;
         err_q     <= '0;
         dma_src_q <= '0;
         dma_dst_q <= '0;
         dma_len_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         act_q   <= act_d;
         // A freeing slot reads as full this cycle, so it cannot also capture.
         full_q  <= (full_q & ~slot_free) | (bus.ch_valid_i & ~full_q);
         irq_q   <= (irq_q & ~bus.irq_clr_i) | irq_set;
         err_q   <= (err_q & ~bus.irq_clr_i) | err_set;
         if (load_dma) begin
            dma_src_q <= src_q[win];
            dma_dst_q <= dst_q[win];
            dma_len_q <= len_q[win];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (bus.ch_valid_i[c] && !full_q[c]) begin
            src_q[c] <= bus.ch_src_i[c*ADDR_W +: ADDR_W];
            dst_q[c] <= bus.ch_dst_i[c*ADDR_W +: ADDR_W];
            len_q[c] <= bus.ch_len_i[c*LEN_W +: LEN_W];
         end
      end
   end

   assign bus.ch_ready_o  = ~full_q;
   assign bus.dma_valid_o = (state_q == S_ISSUE);
   assign bus.dma_src_o   = dma_src_q;
   assign bus.dma_dst_o   = dma_dst_q;
   assign bus.dma_len_o   = dma_len_q;
   assign bus.irq_o       = irq_q;
   assign bus.err_o       = err_q;
   assign bus.busy_o      = (state_q == S_WAIT);
   assign bus.active_ch_o = act_q;
endmodule

// File: tb/tb_dma_ch_sched.sv
// Directed testbench for dma_ch_sched: RR order, backpressure, errors, zero length, reset.
module tb_dma_ch_sched;
   localparam int NUM_CH = 4;
   localparam int ADDR_W = 32;
   localparam int LEN_W  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   ok;
   logic saw;

   always #5 clk = ~clk;

   dma_ch_sched_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   dma_ch_sched #(
      .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYC(20)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   function automatic logic [31:0] src_of(input int c);
      return 32'h0001_0000 + 32'(c) * 32'h100;
   endfunction
   function automatic logic [31:0] dst_of(input int c);
      return 32'h0002_0000 + 32'(c) * 32'h100;
   endfunction
   function automatic logic [15:0] len_of(input int c);
      return 16'h0040 + 16'(c);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [3:0] mask, input bit zero_len);
      for (int c = 0; c < NUM_CH; c++) begin
         bus.ch_src_i[c*ADDR_W +: ADDR_W] = src_of(c);
         bus.ch_dst_i[c*ADDR_W +: ADDR_W] = dst_of(c);
         bus.ch_len_i[c*LEN_W +: LEN_W]   = zero_len ? 16'h0 : len_of(c);
      end
      bus.ch_valid_i = mask;
      tick();
      bus.ch_valid_i = '0;
   endtask

   task automatic wait_valid(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.dma_valid_o === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Grant, accept, then complete a few cycles later with the given err/clear.
   task automatic run_xfer(input int exp_ch, input logic err_bit, input logic [3:0] clr);
      bit f;
      wait_valid(f);
      check("grant_seen", f, 1);
      check("grant_ch", bus.active_ch_o, exp_ch);
      check("grant_src", bus.dma_src_o, src_of(exp_ch));
      check("grant_len", bus.dma_len_o, len_of(exp_ch));
      tick();
      check("busy_wait", bus.busy_o, 1);
      tick();
      tick();
      tick();
      bus.dma_done_i = 1'b1;
      bus.dma_err_i  = err_bit;
      bus.irq_clr_i  = clr;
      tick();
      bus.dma_done_i = 1'b0;
      bus.dma_err_i  = 1'b0;
      bus.irq_clr_i  = '0;
      check("busy_done", bus.busy_o, 0);
      check("slot_freed", bus.ch_ready_o[exp_ch], 1);
   endtask

   task automatic check_reset_state();
      check("rst_ready", bus.ch_ready_o, 4'hF);
      check("rst_valid", bus.dma_valid_o, 0);
      check("rst_src", bus.dma_src_o, 0);
      check("rst_len", bus.dma_len_o, 0);
      check("rst_irq", bus.irq_o, 0);
      check("rst_err", bus.err_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_active", bus.active_ch_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.ch_valid_i  = '0;
      bus.ch_src_i    = '0;
      bus.ch_dst_i    = '0;
      bus.ch_len_i    = '0;
      bus.dma_ready_i = 1'b0;
      bus.dma_done_i  = 1'b0;
      bus.dma_err_i   = 1'b0;
      bus.irq_clr_i   = '0;
      tick();
      tick();
      rst = 1'b0;
      check_reset_state();

      // single channel, latency t+2
      bus.dma_ready_i = 1'b1;
      bus.ch_src_i[2*ADDR_W +: ADDR_W] = 32'h1000;
      bus.ch_dst_i[2*ADDR_W +: ADDR_W] = 32'h2000;
      bus.ch_len_i[2*LEN_W +: LEN_W]   = 16'd64;
      bus.ch_valid_i = 4'b0100;
      tick();
      bus.ch_valid_i = '0;
      check("t1_ready", bus.ch_ready_o, 4'b1011);
      check("t1_valid_t1", bus.dma_valid_o, 0);
      tick();
      check("t1_valid_t2", bus.dma_valid_o, 1);
      check("t1_src", bus.dma_src_o, 32'h1000);
      check("t1_dst", bus.dma_dst_o, 32'h2000);
      check("t1_len", bus.dma_len_o, 16'd64);
      check("t1_active", bus.active_ch_o, 2);
      tick();
      check("t1_busy", bus.busy_o, 1);
      check("t1_valid_off", bus.dma_valid_o, 0);
      bus.dma_done_i = 1'b1;
      tick();
      bus.dma_done_i = 1'b0;
      check("t1_irq", bus.irq_o, 4'b0100);
      check("t1_ready_back", bus.ch_ready_o, 4'hF);
      check("t1_busy_off", bus.busy_o, 0);

      // round robin from pointer 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rr_rst_irq", bus.irq_o, 0);
      load(4'hF, 1'b0);
      for (int k = 0; k < NUM_CH; k++) run_xfer(k, 1'b0, 4'h0);
      check("rr_irq_all", bus.irq_o, 4'hF);
      load(4'b1001, 1'b0);
      run_xfer(0, 1'b0, 4'h0);
      run_xfer(3, 1'b0, 4'h0);

      // backpressure with a competing channel
      bus.irq_clr_i = 4'hF;
      tick();
      bus.irq_clr_i = '0;
      check("bp_irq_clr", bus.irq_o, 0);
      bus.dma_ready_i = 1'b0;
      load(4'b0110, 1'b0);
      wait_valid(ok);
      check("bp_seen", ok, 1);
      for (int i = 0; i < 10; i++) begin
         check("bp_hold", {bus.dma_valid_o, bus.active_ch_o, bus.dma_src_o},
               {1'b1, 2'd1, src_of(1)});
         tick();
      end
      bus.dma_ready_i = 1'b1;
      tick();
      check("bp_busy", bus.busy_o, 1);

      // error completion on ch1, then clear
      bus.dma_done_i = 1'b1;
      bus.dma_err_i  = 1'b1;
      tick();
      bus.dma_done_i = 1'b0;
      bus.dma_err_i  = 1'b0;
      check("err_err", bus.err_o, 4'b0010);
      check("err_irq", bus.irq_o, 4'b0010);
      bus.irq_clr_i = 4'b0010;
      tick();
      bus.irq_clr_i = '0;
      check("clr_irq", bus.irq_o, 0);
      check("clr_err", bus.err_o, 0);
      run_xfer(2, 1'b0, 4'h0);
      check("ch2_irq", bus.irq_o, 4'b0100);
      load(4'b0010, 1'b0);
      run_xfer(1, 1'b0, 4'b0110);
      check("set_wins_irq", bus.irq_o, 4'b0010);
      check("set_wins_err", bus.err_o, 0);

      // zero-length descriptor on ch0
      bus.irq_clr_i = 4'hF;
      tick();
      bus.irq_clr_i = '0;
      load(4'b0001, 1'b1);
      check("zl_valid_a", bus.dma_valid_o, 0);
      check("zl_irq_a", bus.irq_o, 0);
      tick();
      check("zl_irq", bus.irq_o, 4'b0001);
      check("zl_ready", bus.ch_ready_o, 4'hF);
      saw = bus.dma_valid_o;
      for (int i = 0; i < 4; i++) begin
         tick();
         saw = saw | bus.dma_valid_o;
      end
      check("zl_never_valid", saw, 0);

      // reset in WAIT, then stray done
      load(4'b1000, 1'b0);
      wait_valid(ok);
      check("rw_seen", ok, 1);
      tick();
      check("rw_busy", bus.busy_o, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state();
      bus.dma_done_i = 1'b1;
      tick();
      bus.dma_done_i = 1'b0;
      check("stray_irq", bus.irq_o, 0);
      check("stray_busy", bus.busy_o, 0);
      check("stray_ready", bus.ch_ready_o, 4'hF);

`ifdef DMA_SCHED_TIMEOUT_EN
      load(4'b0010, 1'b0);
      wait_valid(ok);
      check("to_seen", ok, 1);
      tick();
      check("to_busy", bus.busy_o, 1);
      repeat (19) tick();
      check("to_err_pre", bus.err_o, 0);
      tick();
      check("to_err", bus.err_o, 4'b0010);
      check("to_irq", bus.irq_o, 4'b0010);
      check("to_busy_off", bus.busy_o, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dma_ch_sched.md
Name: dma_ch_sched

Overview:
Multi-channel descriptor scheduler in front of the p_core_ss DMA engine. It buffers one transfer descriptor (src, dst, len) per software channel and arbitrates between channels round-robin. It issues one descriptor at a time to the DMA and tracks completion. It raises per-channel done/error interrupts toward the core's irq inputs.

Parameters:
NUM_CH, 4, number of requester channels (2..8)
ADDR_W, 32, descriptor address width
LEN_W, 16, transfer length width in bytes
TIMEOUT_CYC, 65535, watchdog limit in cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
ch_valid_i  in  NUM_CH  per-channel descriptor valid
ch_ready_o  out  NUM_CH  per-channel slot empty / can accept
ch_src_i  in  NUM_CH*ADDR_W  source addresses, channel c at [c*ADDR_W +: ADDR_W]
ch_dst_i  in  NUM_CH*ADDR_W  destination addresses, same packing
ch_len_i  in  NUM_CH*LEN_W  lengths, same packing
dma_valid_o  out  1  descriptor to DMA valid
dma_ready_i  in  1  DMA accepts descriptor
dma_src_o  out  ADDR_W  issued source
dma_dst_o  out  ADDR_W  issued destination
dma_len_o  out  LEN_W  issued length
dma_done_i  in  1  one-cycle pulse, transfer complete
dma_err_i  in  1  qualifies dma_done_i, transfer failed
irq_o  out  NUM_CH  sticky per-channel completion interrupt
err_o  out  NUM_CH  sticky per-channel error flag
irq_clr_i  in  NUM_CH  clears irq_o[c] and err_o[c]
busy_o  out  1  a transfer is outstanding
active_ch_o  out  $clog2(NUM_CH)  channel currently issued/in flight

Behaviour:
- Reset, synchronous to clk_i while rst_i=1:
  - All slots empty, so ch_ready_o = all 1s.
  - dma_valid_o=0, dma_src_o/dst_o/len_o=0.
  - irq_o=0, err_o=0, busy_o=0, active_ch_o=0.
  - RR pointer=0, FSM=IDLE.
  - Reset mid-transfer drops the in-flight descriptor. A dma_done_i arriving after reset is ignored (FSM is not in WAIT).
- Slot capture: on ch_valid_i[c] & ch_ready_o[c], the descriptor is latched and ch_ready_o[c] drops the next cycle. The slot frees in the cycle after that channel's dma_done_i.
- FSM IDLE: if any slot is full, select the winner and go to ISSUE.
  - Winner is the first full slot at or after the RR pointer, wrapping modulo NUM_CH.
  - The RR pointer updates to winner+1 (mod NUM_CH) on grant.
- FSM ISSUE:
  - dma_valid_o=1 with the winner's fields; active_ch_o=winner.
  - Fields are held stable until dma_ready_i.
  - On valid&ready, go to WAIT with busy_o=1.
- FSM WAIT: on dma_done_i:
  - Set irq_o[active]; set err_o[active] if dma_err_i.
  - Free the slot; busy_o=0; go to IDLE.
  - Minimum gap between two grants is 1 IDLE cycle.
- Zero length: a descriptor with len=0 is never issued to the DMA.
  - On grant, the FSM goes IDLE->IDLE, sets irq_o[c], and frees the slot in the same cycle.
- Simultaneous events:
  - If irq_clr_i[c] and a set for c occur in the same cycle, the set wins (irq stays 1).
  - A new ch_valid_i on a channel whose slot frees this cycle is not accepted until ready_o is observed high.
- Stray dma_done_i outside WAIT is ignored.
- Latency: descriptor accepted at cycle t with the FSM idle and no contention gives dma_valid_o=1 at t+2.
- Fairness: with all channels continuously requesting, each channel is granted exactly once every NUM_CH grants.

Optional Feature:
DMA_SCHED_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT and resets on entry to WAIT.
  - If it reaches TIMEOUT_CYC without dma_done_i, the block sets err_o[active] and irq_o[active], frees the slot, and returns to IDLE.
  - A later dma_done_i is ignored unless the FSM has re-entered WAIT.
- Undefined: no counter; WAIT persists indefinitely until dma_done_i.

Test Plan:
- Single channel: ch2 src=0x1000 dst=0x2000 len=64, dma_ready_i=1 -> dma_valid_o at t+2 with those fields, active_ch_o=2. Done pulse -> irq_o=4'b0100, ch_ready_o[2]=1 next cycle.
- All 4 channels loaded at once, RR pointer=0, DMA always ready, done 5 cycles after each issue -> grant order 0,1,2,3. Reload ch0 and ch3 -> order 0,3.
- Backpressure: dma_ready_i=0 for 10 cycles -> dma_valid_o held 1 with stable fields for 10 cycles, no other channel granted.
- Error and clear: dma_done_i with dma_err_i=1 on ch1 -> err_o[1]=1, irq_o[1]=1. irq_clr_i[1] -> both 0. Clear coincident with a new done on ch1 -> irq_o[1] stays 1.
- Zero length: ch0 len=0 -> dma_valid_o never asserted, irq_o[0]=1 within 2 cycles of acceptance.
- Reset mid-WAIT, then stray dma_done_i -> all outputs at reset values, irq_o stays 0. With DMA_SCHED_TIMEOUT_EN and TIMEOUT_CYC=20, no done -> err_o[active]=1 on cycle 20 of WAIT.
